// File: rtl/svc_rv_soc_run_ctrl_pkg.sv
// svc_rv_soc_run_ctrl_pkg: shared state/status types for the run sequencer
package svc_rv_soc_run_ctrl_pkg;
  localparam int STATUS_W = 2;
  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_e;
  typedef enum logic [STATUS_W-1:0] {
    STATUS_EBREAK  = 2'd0,
    STATUS_TIMEOUT = 2'd1,
    STATUS_ABORT   = 2'd2
  } status_e;
endpackage

// File: rtl/svc_rv_soc_run_ctrl_satcnt.sv
// svc_rv_soc_run_ctrl_satcnt: clear/enable saturating up-counter
module svc_rv_soc_run_ctrl_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  // clear wins over enable; the count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/svc_rv_soc_run_ctrl.sv
// svc_rv_soc_run_ctrl: core reset/run sequencer with cycle count result; SVC_RV_SOC_RUN_CTRL_STATS_EN adds run id and timeout count
module svc_rv_soc_run_ctrl
  import svc_rv_soc_run_ctrl_pkg::*;
#(
  parameter int CYCLE_W    = 32,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                abort,
  output logic                core_rst_n,
  input  logic                ebreak,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CYCLE_W-1:0]  res_cycles,
  output logic [STATUS_W-1:0] res_status
`ifdef SVC_RV_SOC_RUN_CTRL_STATS_EN
  ,
  output logic [15:0]         res_run_id,
  output logic [7:0]          timeout_count
`endif
);
  localparam int HOLD_W = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  state_e state;
  logic [HOLD_W-1:0] hold;
  logic [CYCLE_W-1:0] cnt;
  logic hit_to, fin;
  status_e fin_status;
  assign start_ready = state == IDLE;
  assign busy = state == RESET || state == RUN;
  assign res_valid = state == DONE;
  assign core_rst_n = state == RUN || state == DONE;
  assign hit_to = TIMEOUT != 0 && 64'(cnt) == 64'(TIMEOUT);
  assign fin = state == RUN && (ebreak || hit_to || abort);
  assign fin_status = ebreak ? STATUS_EBREAK : hit_to ? STATUS_TIMEOUT : STATUS_ABORT;
  // stepping on the last RESET cycle makes the count read 1 on the first RUN cycle
  svc_rv_soc_run_ctrl_satcnt #(.W(CYCLE_W)) u_cyc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == IDLE),
    .en(state == RUN || (state == RESET && hold == '0)),
    .q(cnt)
  );
  // sequencer: IDLE -> RESET (hold) -> RUN (count) -> DONE (present result)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hold <= '0;
      res_cycles <= '0;
      res_status <= '0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          state <= RESET;
          hold <= HOLD_W'(RST_CYCLES - 1);
        end
        RESET: begin
          hold <= hold - 1'b1;
          if (hold == '0) state <= RUN;
        end
        RUN: if (fin) begin
          state <= DONE;
          res_cycles <= cnt;
          res_status <= fin_status;
        end
        default: if (res_ready) state <= IDLE;
      endcase
    end
`ifdef SVC_RV_SOC_RUN_CTRL_STATS_EN
  // run id advances when a result is consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) res_run_id <= '0;
    else if (state == DONE && res_ready) res_run_id <= res_run_id + 1'b1;
  svc_rv_soc_run_ctrl_satcnt #(.W(8)) u_to (
    .clk(clk),
    .rst_n(rst_n),
    .clr(1'b0),
    .en(fin && fin_status == STATUS_TIMEOUT),
    .q(timeout_count)
  );
`endif
endmodule

// File: tb/tb_svc_rv_soc_run_ctrl.sv
// tb_svc_rv_soc_run_ctrl: scoreboard bench for the run sequencer
module tb_svc_rv_soc_run_ctrl;
  logic clk = 0, rst_n = 0;
  logic start_valid = 0, abort = 0, ebreak = 0, res_ready = 0;
  logic start_ready, core_rst_n, busy, res_valid;
  logic [31:0] res_cycles;
  logic [1:0] res_status;
  logic s_start = 0, s_ebreak = 0;
  logic s_start_ready, s_core_rst_n, s_busy, s_res_valid;
  logic [3:0] s_res_cycles;
  logic [1:0] s_res_status;
`ifdef SVC_RV_SOC_RUN_CTRL_STATS_EN
  logic [15:0] res_run_id, s_res_run_id;
  logic [7:0] timeout_count, s_timeout_count;
`endif
  typedef struct packed {logic [1:0] st; logic [31:0] cyc;} res_t;
  res_t sb[$];
  int checks = 0, errors = 0;
  int exp_id = 0, exp_to = 0;

  always #5 clk = ~clk;

  svc_rv_soc_run_ctrl #(.CYCLE_W(32), .RST_CYCLES(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .abort(abort), .core_rst_n(core_rst_n), .ebreak(ebreak), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_cycles(res_cycles),
    .res_status(res_status)
`ifdef SVC_RV_SOC_RUN_CTRL_STATS_EN
    , .res_run_id(res_run_id), .timeout_count(timeout_count)
`endif
  );

  svc_rv_soc_run_ctrl #(.CYCLE_W(4), .RST_CYCLES(4), .TIMEOUT(0)) dut_small (
    .clk(clk), .rst_n(rst_n), .start_valid(s_start), .start_ready(s_start_ready),
    .abort(1'b0), .core_rst_n(s_core_rst_n), .ebreak(s_ebreak), .busy(s_busy),
    .res_valid(s_res_valid), .res_ready(1'b0), .res_cycles(s_res_cycles),
    .res_status(s_res_status)
`ifdef SVC_RV_SOC_RUN_CTRL_STATS_EN
    , .res_run_id(s_res_run_id), .timeout_count(s_timeout_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run;
    int n;
    start_valid = 1;
    tick;
    start_valid = 0;
    check("busy_reset", busy, 1);
    n = 0;
    while (!core_rst_n && n < 50) begin
      n++;
      tick;
    end
    check("reset_hold", n, 4);
  endtask

  task automatic run_to(input int k, input bit eb, input bit ab, input logic [1:0] st);
    int c;
    c = 1;
    sb.push_back('{st: st, cyc: 32'(k)});
    if (st == 2'd1) exp_to++;
    while (!res_valid && c < 400) begin
      ebreak = eb && c == k;
      abort = ab && c == k;
      tick;
      c++;
    end
    ebreak = 0;
    abort = 0;
    check("done_latency", c, k + 1);
    check("busy_done", busy, 0);
  endtask

  task automatic consume;
    res_t e;
    check("res_valid", res_valid, 1);
    check("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("res_cycles", res_cycles, e.cyc);
      check("res_status", res_status, e.st);
    end
`ifdef SVC_RV_SOC_RUN_CTRL_STATS_EN
    check("run_id", res_run_id, exp_id);
    check("timeout_count", timeout_count, exp_to);
`endif
    res_ready = 1;
    tick;
    res_ready = 0;
    exp_id++;
    check("core_rst_idle", core_rst_n, 0);
    check("start_ready_idle", start_ready, 1);
    check("res_valid_idle", res_valid, 0);
  endtask

  initial begin
    int n;
    repeat (3) tick;
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_start_ready", start_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_cycles", res_cycles, 0);
    check("rst_res_status", res_status, 0);
    rst_n = 1;
    tick;
    start_run; run_to(37, 1, 0, 2'd0); consume;
    start_run; run_to(100, 0, 0, 2'd1); consume;
    start_run; run_to(100, 1, 0, 2'd0); consume;
    start_run; run_to(10, 0, 1, 2'd2); consume;
    abort = 1;
    repeat (3) tick;
    check("abort_idle_ready", start_ready, 1);
    start_run; run_to(12, 1, 0, 2'd0); consume;
    ebreak = 1;
    repeat (2) tick;
    check("ebreak_idle_ready", start_ready, 1);
    start_run; run_to(1, 1, 0, 2'd0); consume;
    start_run; run_to(20, 0, 1, 2'd2);
    for (int i = 0; i < 20; i++) begin
      start_valid = i[0];
      ebreak = ~i[0];
      tick;
      check("hold_valid", res_valid, 1);
      check("hold_start_ready", start_ready, 0);
      check("hold_core_rst", core_rst_n, 1);
      check("hold_cycles", res_cycles, sb[0].cyc);
      check("hold_status", res_status, sb[0].st);
    end
    start_valid = 0;
    ebreak = 0;
    consume;
    start_run;
    repeat (4) tick;
    rst_n = 0;
    #1;
    check("arst_core_rst", core_rst_n, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_start_ready", start_ready, 1);
    exp_id = 0;
    exp_to = 0;
    @(negedge clk);
    rst_n = 1;
    tick;
    check("arst_idle", start_ready, 1);
    start_run; run_to(7, 1, 0, 2'd0); consume;
    s_start = 1;
    tick;
    s_start = 0;
    n = 0;
    while (!s_core_rst_n && n < 50) begin
      n++;
      tick;
    end
    check("small_reset_hold", n, 4);
    repeat (29) tick;
    check("small_running", s_res_valid, 0);
    s_ebreak = 1;
    tick;
    s_ebreak = 0;
    check("small_valid", s_res_valid, 1);
    check("small_cycles_sat", s_res_cycles, 15);
    check("small_status", s_res_status, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
